// File: rtl/lerp_upsamp.sv
// Linear-interpolating upsampler: pops one FIFO sample per 2^SAMPLE_RATE clocks and ramps between samples.
// Build option: define LERP_ROUND_EN for round-half-up interpolation (default is floor).
module lerp_upsamp #(
  parameter int DATA_WIDTH  = 14,
  parameter int SAMPLE_RATE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  fifo_empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] inter_data,
  output logic                  out_valid,
  output logic                  underflow
);

  localparam int DW = DATA_WIDTH;
  localparam int SR = SAMPLE_RATE;
  localparam int PW = DW + SR + 1;
  localparam logic [SR-1:0] K_LAST = '1;
  localparam logic [SR-1:0] K_PRE  = K_LAST - 1'b1;
`ifdef LERP_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(1) << (SR - 1);
`endif

  typedef enum logic [2:0] {IDLE, PRIME, RUN, STARVE, RELOAD} state_t;

  state_t        state_q, state_d;
  logic [SR-1:0] k_q, k_d;
  logic [DW-1:0] s0_q, s0_d;
  logic [DW-1:0] s1_q, s1_d;
  logic [DW-1:0] inter_q, inter_d;
  logic          valid_q, valid_d;
  logic          under_q, under_d;
  logic          pend_q, pend_d;
  logic          starve_q, starve_d;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_r;
  logic [DW-1:0]        lerp;

  // Product bits above DW are discarded after the shift; the result stays within [s0, s1].
  always_comb begin
    diff = {s1_q[DW-1], s1_q} - {s0_q[DW-1], s0_q};
    prod = {{SR{diff[DW]}}, diff} * {{(DW+1){1'b0}}, k_q};
`ifdef LERP_ROUND_EN
    prod_r = prod + RND;
`else
    prod_r = prod;
`endif
    lerp = s0_q + DW'(prod_r >>> SR);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    inter_d  = inter_q;
    valid_d  = valid_q;
    under_d  = under_q;
    pend_d   = pend_q;
    starve_d = starve_q;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (ena && !fifo_empty) begin
          rd_en   = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        s0_d    = dataIn;
        s1_d    = dataIn;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        inter_d = lerp;
        valid_d = 1'b1;
        k_d     = k_q + 1'b1;
        // Read one phase early so the next sample lands exactly at the wrap.
        if (k_q == K_PRE) begin
          rd_en    = ena && !fifo_empty;
          pend_d   = ena && !fifo_empty;
          starve_d = ena && fifo_empty;
        end
        if (k_q == K_LAST) begin
          k_d = '0;
          if (pend_q) begin
            s0_d = s1_q;
            s1_d = dataIn;
          end else if (starve_q) begin
            state_d = STARVE;
            under_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STARVE: begin
        inter_d = s1_q;
        valid_d = 1'b1;
        if (!ena) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          rd_en   = 1'b1;
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        inter_d = s1_q;
        valid_d = 1'b1;
        s0_d    = s1_q;
        s1_d    = dataIn;
        k_d     = '0;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (rst) rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      inter_q  <= '0;
      valid_q  <= 1'b0;
      under_q  <= 1'b0;
      pend_q   <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      inter_q  <= inter_d;
      valid_q  <= valid_d;
      under_q  <= under_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end

  assign inter_data = inter_q;
  assign out_valid  = valid_q;
  assign underflow  = under_q;

endmodule

// File: tb/tb_lerp_upsamp.sv
// Directed self-checking bench for lerp_upsamp (DATA_WIDTH=14, SAMPLE_RATE=4, L=16).
module tb_lerp_upsamp;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ena = 1'b0;
  logic               fifo_empty;
  logic               rd_en;
  logic [13:0]        dataIn = '0;
  logic signed [13:0] inter_data;
  logic               out_valid;
  logic               underflow;

  int errs = 0;
  int checks = 0;
  int rd_cnt = 0;
  int rd_ptr = 0;
  int wr_ptr = 0;
  logic [13:0] fmem [16];

`ifdef LERP_ROUND_EN
  localparam int E3_1  = 1563;
  localparam int E3_15 = 1038;
  int exp6 [16] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3, 3};
`else
  localparam int E3_1  = 1562;
  localparam int E3_15 = 1037;
  int exp6 [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2};
`endif

  lerp_upsamp #(.DATA_WIDTH(14), .SAMPLE_RATE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .fifo_empty (fifo_empty),
    .rd_en      (rd_en),
    .dataIn     (dataIn),
    .inter_data (inter_data),
    .out_valid  (out_valid),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // FIFO model with one-cycle read latency.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_ptr != wr_ptr) begin
        dataIn <= fmem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    fmem[wr_ptr] = 14'(v);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    push(0); push(1600); push(1000); push(-600); push(0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({inter_data, out_valid, underflow, rd_en} !== 17'd0) begin
        errs++;
        $display("FAIL reset_outputs cyc=%0d got inter=%0d valid=%b uf=%b rd=%b exp all 0",
                 i, inter_data, out_valid, underflow, rd_en);
      end
    end
    checks++;
    if (rd_cnt !== 0) begin
      errs++;
      $display("FAIL reset_no_read got=%0d exp=0", rd_cnt);
    end
  endtask

  task automatic test_ramp();
    int c0;
    rst = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin errs++; $display("FAIL idle_launch_rd got=%b exp=1", rd_en); end
    step();
    checks++;
    if ({rd_en, out_valid} !== 2'b00) begin
      errs++; $display("FAIL prime_state got rd=%b valid=%b exp 0 0", rd_en, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL latency_valid got=%b exp=0", out_valid); end
    c0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || inter_data !== 14'sd0) begin
        errs++; $display("FAIL seg_flat k=%0d got=%0d/%b exp=0/1", i, inter_data, out_valid);
      end
    end
    checks++;
    if (rd_cnt - c0 !== 1) begin errs++; $display("FAIL seg1_reads got=%0d exp=1", rd_cnt - c0); end
    c0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || inter_data !== 14'(100 * i)) begin
        errs++; $display("FAIL ramp k=%0d got=%0d/%b exp=%0d/1", i, inter_data, out_valid, 100 * i);
      end
    end
    checks++;
    if (rd_cnt - c0 !== 1) begin errs++; $display("FAIL seg2_reads got=%0d exp=1", rd_cnt - c0); end
  endtask

  task automatic test_neg_slope();
    int e;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0 || i == 1 || i == 2 || i == 15) begin
        e = (i == 0) ? 1600 : (i == 1) ? E3_1 : (i == 2) ? 1525 : E3_15;
        checks++;
        if (inter_data !== 14'(e)) begin
          errs++; $display("FAIL neg_slope k=%0d got=%0d exp=%0d", i, inter_data, e);
        end
      end
    end
  endtask

  task automatic test_cross_zero();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (inter_data !== 14'(1000 - 100 * i)) begin
        errs++; $display("FAIL cross_zero k=%0d got=%0d exp=%0d", i, inter_data, 1000 - 100 * i);
      end
    end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (underflow !== (i == 15) || out_valid !== 1'b1) begin
        errs++; $display("FAIL starve_flag k=%0d got uf=%b valid=%b exp uf=%b valid=1",
                         i, underflow, out_valid, i == 15);
      end
      if (i == 0) begin
        checks++;
        if (inter_data !== -14'sd600) begin
          errs++; $display("FAIL seg5_start got=%0d exp=-600", inter_data);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (inter_data !== 14'sd0 || out_valid !== 1'b1 || rd_en !== 1'b0 || underflow !== 1'b1) begin
        errs++; $display("FAIL starve_hold cyc=%0d got inter=%0d valid=%b rd=%b uf=%b exp 0 1 0 1",
                         j, inter_data, out_valid, rd_en, underflow);
      end
    end
    push(3);
    #1;
    checks++;
    if (rd_en !== 1'b1) begin errs++; $display("FAIL refill_rd got=%b exp=1", rd_en); end
    for (int j = 0; j < 2; j++) begin
      step();
      checks++;
      if (inter_data !== 14'sd0 || out_valid !== 1'b1) begin
        errs++; $display("FAIL reload_hold cyc=%0d got=%0d/%b exp=0/1", j, inter_data, out_valid);
      end
    end
  endtask

  task automatic test_round();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (inter_data !== 14'(exp6[i]) || out_valid !== 1'b1) begin
        errs++; $display("FAIL round k=%0d got=%0d/%b exp=%0d/1", i, inter_data, out_valid, exp6[i]);
      end
    end
  endtask

  task automatic test_ena_drop();
    int c0;
    push(163);
    push(500);
    #1;
    checks++;
    if (rd_en !== 1'b1) begin errs++; $display("FAIL starve_refill_rd got=%b exp=1", rd_en); end
    step();
    step();
    c0 = rd_cnt;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 2) ena = 1'b0;
      checks++;
      if (inter_data !== 14'(3 + 10 * i) || out_valid !== 1'b1) begin
        errs++; $display("FAIL ena_drop_seg k=%0d got=%0d/%b exp=%0d/1", i, inter_data, out_valid, 3 + 10 * i);
      end
    end
    checks++;
    if (rd_cnt - c0 !== 0) begin errs++; $display("FAIL ena_drop_reads got=%0d exp=0", rd_cnt - c0); end
    for (int j = 0; j < 2; j++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || inter_data !== 14'sd153 || rd_en !== 1'b0) begin
        errs++; $display("FAIL idle_hold cyc=%0d got valid=%b inter=%0d rd=%b exp 0 153 0",
                         j, out_valid, inter_data, rd_en);
      end
    end
  endtask

  task automatic test_rst_mid();
    ena = 1'b1;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin errs++; $display("FAIL restart_rd got=%b exp=1", rd_en); end
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (inter_data !== 14'sd500 || out_valid !== 1'b1) begin
        errs++; $display("FAIL const_seg k=%0d got=%0d/%b exp=500/1", i, inter_data, out_valid);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin errs++; $display("FAIL rst_rd_mask got=%b exp=0", rd_en); end
    step();
    checks++;
    if ({inter_data, out_valid, underflow, rd_en} !== 17'd0) begin
      errs++; $display("FAIL rst_mid got inter=%0d valid=%b uf=%b rd=%b exp all 0",
                       inter_data, out_valid, underflow, rd_en);
    end
    rst = 1'b0;
    ena = 1'b0;
    step();
    checks++;
    if ({inter_data, out_valid, underflow, rd_en} !== 17'd0) begin
      errs++; $display("FAIL post_rst got inter=%0d valid=%b uf=%b rd=%b exp all 0",
                       inter_data, out_valid, underflow, rd_en);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_neg_slope();
    test_cross_zero();
    test_starve();
    test_round();
    test_ena_drop();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
